// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU and its issue controller.
//   - instruction opcodes (OP and OPC forms, memory ops)
//   - ALUFN function codes driven onto the ALU
//   - OPC offset, issue-controller state encoding, decode record
//   - op_alufn(): maps an OP-form opcode to {legal, alufn}
package alu_pkg;

  localparam logic [5:0] OPC_OFFSET = 6'h10;

  // OP-form opcodes; the OPC form of each is opcode + OPC_OFFSET
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h21;
  localparam logic [5:0] OP_MUL   = 6'h22;
  localparam logic [5:0] OP_CMPEQ = 6'h24;
  localparam logic [5:0] OP_CMPLT = 6'h25;
  localparam logic [5:0] OP_CMPLE = 6'h26;
  localparam logic [5:0] OP_AND   = 6'h28;
  localparam logic [5:0] OP_OR    = 6'h29;
  localparam logic [5:0] OP_XOR   = 6'h2A;
  localparam logic [5:0] OP_SHL   = 6'h2C;
  localparam logic [5:0] OP_SHR   = 6'h2D;
  localparam logic [5:0] OP_SRA   = 6'h2E;
  localparam logic [5:0] OP_LD    = 6'h18;
  localparam logic [5:0] OP_ST    = 6'h19;
  localparam logic [5:0] OP_LDR   = 6'h1F;

  localparam logic [5:0] ALUFN_ADD   = 6'h00;
  localparam logic [5:0] ALUFN_SUB   = 6'h01;
  localparam logic [5:0] ALUFN_MUL   = 6'h02;
  localparam logic [5:0] ALUFN_CMPEQ = 6'h33;
  localparam logic [5:0] ALUFN_CMPLT = 6'h35;
  localparam logic [5:0] ALUFN_CMPLE = 6'h37;
  localparam logic [5:0] ALUFN_AND   = 6'h18;
  localparam logic [5:0] ALUFN_OR    = 6'h1E;
  localparam logic [5:0] ALUFN_XOR   = 6'h16;
  localparam logic [5:0] ALUFN_SHL   = 6'h20;
  localparam logic [5:0] ALUFN_SHR   = 6'h21;
  localparam logic [5:0] ALUFN_SRA   = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0] alufn;
    logic       use_literal;
    logic       illegal;
  } decode_t;

  // Returns {legal, alufn} for an OP-form opcode (0x20..0x2F).
  function automatic logic [6:0] op_alufn(input logic [5:0] op);
    logic [6:0] res;
    res = {1'b0, ALUFN_ADD};
    case (op)
      OP_ADD:   res = {1'b1, ALUFN_ADD};
      OP_SUB:   res = {1'b1, ALUFN_SUB};
      OP_MUL:   res = {1'b1, ALUFN_MUL};
      OP_CMPEQ: res = {1'b1, ALUFN_CMPEQ};
      OP_CMPLT: res = {1'b1, ALUFN_CMPLT};
      OP_CMPLE: res = {1'b1, ALUFN_CMPLE};
      OP_AND:   res = {1'b1, ALUFN_AND};
      OP_OR:    res = {1'b1, ALUFN_OR};
      OP_XOR:   res = {1'b1, ALUFN_XOR};
      OP_SHL:   res = {1'b1, ALUFN_SHL};
      OP_SHR:   res = {1'b1, ALUFN_SHR};
      OP_SRA:   res = {1'b1, ALUFN_SRA};
      default:  res = {1'b0, ALUFN_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode decoder.
//   i_opcode  in  6  instruction opcode
//   o_dec     out    {alufn, use_literal, illegal}
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] i_opcode,
  output decode_t    o_dec
);

  logic [6:0] w_lookup;

  // Opcodes 0x20..0x3F carry the OPC flag in bit 4; clearing it folds the
  // literal form onto its register form for the function lookup.
  assign w_lookup = op_alufn(i_opcode & ~OPC_OFFSET);

  always_comb begin
    o_dec.alufn       = ALUFN_ADD;
    o_dec.use_literal = 1'b0;
    o_dec.illegal     = 1'b1;
    if (i_opcode[5]) begin
      o_dec.alufn       = w_lookup[5:0];
      o_dec.use_literal = i_opcode[4];
      o_dec.illegal     = ~w_lookup[6];
    end else if (i_opcode == OP_LD || i_opcode == OP_ST || i_opcode == OP_LDR) begin
      // Memory ops compute an effective address: ra + sign-extended literal
      o_dec.alufn       = ALUFN_ADD;
      o_dec.use_literal = 1'b1;
      o_dec.illegal     = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded operation to the combinational ALU,
// holds its inputs for SETTLE_CYCLES, then captures result and flags.
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            operation handshake
//   in_opcode, in_ra, in_rb, in_lit  operation fields
//   alufn, alu_a, alu_b          registered ALU drive
//   alu_result, alu_z/v/n        ALU response
//   out_valid/out_ready          result handshake
//   out_result, out_z/v/n, out_illop  captured result
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_ra,
  input  logic [31:0] in_rb,
  input  logic [15:0] in_lit,
  output logic [5:0]  alufn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_z,
  output logic        out_v,
  output logic        out_n,
  output logic        out_illop
);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_illop_pend;
  logic [5:0]  r_alufn;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_result;
  logic        r_z;
  logic        r_v;
  logic        r_n;
  logic        r_illop;

  decode_t     w_dec;
  logic [31:0] w_lit_sext;

  alu_op_decode u_decode (
    .i_opcode (in_opcode),
    .o_dec    (w_dec)
  );

  assign w_lit_sext = {{16{in_lit[15]}}, in_lit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_illop_pend <= 1'b0;
      r_alufn      <= ALUFN_ADD;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_result     <= 32'd0;
      r_z          <= 1'b0;
      r_v          <= 1'b0;
      r_n          <= 1'b0;
      r_illop      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= ST_EXEC;
            if (w_dec.illegal) begin
              // Illegal ops spend one EXEC cycle so the result appears one
              // edge after accept; the ALU drive keeps its previous values.
              r_illop_pend <= 1'b1;
              r_cnt        <= 4'd0;
            end else begin
              r_illop_pend <= 1'b0;
              r_cnt        <= 4'(SETTLE_CYCLES - 1);
              r_alufn      <= w_dec.alufn;
              r_alu_a      <= in_ra;
              r_alu_b      <= w_dec.use_literal ? w_lit_sext : in_rb;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            if (r_illop_pend) begin
              r_result <= 32'd0;
              r_z      <= 1'b0;
              r_v      <= 1'b0;
              r_n      <= 1'b0;
              r_illop  <= 1'b1;
            end else begin
              r_result <= alu_result;
              r_z      <= alu_z;
              r_v      <= alu_v;
              r_n      <= alu_n;
              r_illop  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign alufn      = r_alufn;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign out_result = r_result;
  assign out_z      = r_z;
  assign out_v      = r_v;
  assign out_n      = r_n;
  assign out_illop  = r_illop;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_ra;
  logic [31:0] in_rb;
  logic [15:0] in_lit;
  logic [5:0]  alufn;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_z;
  logic        out_v;
  logic        out_n;
  logic        out_illop;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_lit     (in_lit),
    .alufn      (alufn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_z      (out_z),
    .out_v      (out_v),
    .out_n      (out_n),
    .out_illop  (out_illop)
  );

  // Behavioural ALU standing in for the real combinational datapath
  always_comb begin
    alu_result = 32'd0;
    alu_v      = 1'b0;
    case (alufn)
      6'h00: begin
        alu_result = alu_a + alu_b;
        alu_v = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      6'h01: begin
        alu_result = alu_a - alu_b;
        alu_v = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      6'h02: alu_result = alu_a * alu_b;
      6'h33: alu_result = {31'd0, alu_a == alu_b};
      6'h35: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'h37: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      6'h18: alu_result = alu_a & alu_b;
      6'h1E: alu_result = alu_a | alu_b;
      6'h16: alu_result = alu_a ^ alu_b;
      6'h20: alu_result = alu_a << alu_b[4:0];
      6'h21: alu_result = alu_a >> alu_b[4:0];
      6'h23: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
    alu_z = (alu_result == 32'd0);
    alu_n = alu_result[31];
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [15:0] lit;
    logic [5:0]  e_alufn;
    logic [31:0] e_b;
    logic [31:0] e_res;
    logic        e_z;
    logic        e_v;
    logic        e_n;
    logic        e_ill;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present an op at the negedge; returns #1 after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [15:0] lit);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_ra     = ra;
    in_rb     = rb;
    in_lit    = lit;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid, bounded.
  task automatic wait_valid(input int exp_lat, input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, cyc, exp_lat);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_alufn"},     {26'd0, alufn},     32'd0);
    check({tag, "_alu_a"},     alu_a,              32'd0);
    check({tag, "_alu_b"},     alu_b,              32'd0);
    check({tag, "_result"},    out_result,         32'd0);
    check({tag, "_flags"},     {28'd0, out_z, out_v, out_n, out_illop}, 32'd0);
  endtask

  initial begin
    logic [5:0]  last_alufn;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [31:0] hold_res;

    //          op     ra            rb            lit       alufn  alu_b         result        z     v     n     ill
    vecs[0]  = '{6'h20, 32'd5,        32'd7,        16'h0000, 6'h00, 32'd7,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{6'h31, 32'd3,        32'd99,       16'h0003, 6'h01, 32'd3,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{6'h30, 32'd10,       32'd0,        16'hFFFE, 6'h00, 32'hFFFFFFFE, 32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'h25, 32'hFFFFFFFF, 32'd1,        16'h0000, 6'h35, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'h26, 32'd4,        32'd4,        16'h0000, 6'h37, 32'd4,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'h21, 32'h80000000, 32'd1,        16'h0000, 6'h01, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{6'h28, 32'h0000F0F0, 32'h0000FF00, 16'h0000, 6'h18, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'h3C, 32'd1,        32'd31,       16'h0004, 6'h20, 32'd4,        32'd16,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'h18, 32'h00000100, 32'd0,        16'hFFFC, 6'h00, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'h2E, 32'h80000000, 32'd4,        16'h0000, 6'h23, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{6'h2A, 32'h00001234, 32'h00001234, 16'h0000, 6'h16, 32'h00001234, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'h20, 32'h7FFFFFFF, 32'd1,        16'h0000, 6'h00, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{6'h22, 32'd3,        32'd5,        16'h0000, 6'h02, 32'd5,        32'd15,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'h03, 32'd77,       32'd88,       16'h1234, 6'h02, 32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{6'h23, 32'd11,       32'd22,       16'h0001, 6'h02, 32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 6'h00; in_ra = 32'd0; in_rb = 32'd0; in_lit = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // out_ready while idle must not disturb anything
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_ready_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_ready_out_valid", {31'd0, out_valid}, 32'd0);

    last_alufn = 6'h00; last_a = 32'd0; last_b = 32'd0;
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].lit);
      if (!vecs[i].e_ill) begin
        last_alufn = vecs[i].e_alufn;
        last_a     = vecs[i].ra;
        last_b     = vecs[i].e_b;
      end
      check($sformatf("v%0d_alufn", i), {26'd0, alufn}, {26'd0, last_alufn});
      check($sformatf("v%0d_alu_a", i), alu_a, last_a);
      check($sformatf("v%0d_alu_b", i), alu_b, last_b);
      check($sformatf("v%0d_in_ready_busy", i), {31'd0, in_ready}, 32'd0);
      wait_valid(vecs[i].e_ill ? 1 : SETTLE, $sformatf("v%0d_latency", i));
      check($sformatf("v%0d_result", i), out_result, vecs[i].e_res);
      check($sformatf("v%0d_zvn_ill", i), {28'd0, out_z, out_v, out_n, out_illop},
            {28'd0, vecs[i].e_z, vecs[i].e_v, vecs[i].e_n, vecs[i].e_ill});
      $display("vec %0d op=0x%02h alufn=0x%02h b=0x%08h result=0x%08h zvn=%b%b%b ill=%b",
               i, vecs[i].op, alufn, alu_b, out_result, out_z, out_v, out_n, out_illop);
      drain();
    end

    // Backpressure: result held five cycles, then accept right after release
    issue(6'h20, 32'd1, 32'd2, 16'h0000);
    wait_valid(SETTLE, "bp_latency");
    hold_res = out_result;
    check("bp_result", hold_res, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_result", out_result, 32'd3);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    drain();
    check("bp_ready_after_release", {31'd0, in_ready}, 32'd1);
    issue(6'h29, 32'h0000000F, 32'h000000F0, 16'h0000);
    check("bp_next_alufn", {26'd0, alufn}, 32'h1E);
    wait_valid(SETTLE, "bp_next_latency");
    check("bp_next_result", out_result, 32'h000000FF);
    $display("backpressure sequence result=0x%08h", out_result);
    drain();

    // Reset in the middle of EXEC
    issue(6'h21, 32'd9, 32'd4, 16'h0000);
    check("rst_exec_alufn_pre", {26'd0, alufn}, 32'h01);
    pulse_reset();
    check_reset_state("rst_exec");
    $display("reset during EXEC: out_valid=%b in_ready=%b alufn=0x%02h", out_valid, in_ready, alufn);

    // Reset while DONE with out_ready low (illegal op pending)
    issue(6'h3F, 32'd1, 32'd1, 16'h0001);
    wait_valid(1, "rst_done_latency");
    check("rst_done_illop_pre", {31'd0, out_illop}, 32'd1);
    pulse_reset();
    check_reset_state("rst_done");
    $display("reset during DONE: out_valid=%b out_illop=%b", out_valid, out_illop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
